// File: rtl/dcm_pkg.sv
// dcm_pkg: shared types and constants for the DCM phase-shift controller.
//   PHASE_W     width of signed phase-step values
//   RELOCK_W    width of the lock-loss recovery counter
//   STATUS_W    width of the DCM STATUS bus
//   phase_t     signed phase-step type
//   ps_state_t  controller state enumeration
//   clamp_phase clamps a phase target to [-lim, +lim]
package dcm_pkg;

   localparam int unsigned PHASE_W  = 9;
   localparam int unsigned RELOCK_W = 8;
   localparam int unsigned STATUS_W = 8;

   typedef logic signed [PHASE_W-1:0] phase_t;

   typedef enum logic [2:0] {
      RST_DCM   = 3'd0,
      WAIT_LOCK = 3'd1,
      IDLE      = 3'd2,
      STEP      = 3'd3,
      WAIT_DONE = 3'd4
   } ps_state_t;

   // Saturate a signed target into the symmetric legal phase window.
   function automatic phase_t clamp_phase(input phase_t t, input int lim);
      int v;
      v = int'(t);
      if (v > lim) begin
         v = lim;
      end else if (v < -lim) begin
         v = -lim;
      end
      return PHASE_W'(v);
   endfunction

endpackage

// File: rtl/dcm_ps_ctrl_if.sv
// dcm_ps_ctrl_if: user-side request/status bundle of the phase-shift controller.
//   req         one-cycle request to move the phase to target
//   target      signed target phase in steps
//   busy        high while stepping, resetting or waiting for lock
//   cur_phase   signed current phase in steps
//   ready       DCM locked and controller idle
//   err_ovf     sticky DCM phase-overflow flag
//   relock_cnt  saturating count of lock-loss recoveries
// master = requester, slave = controller.
interface dcm_ps_ctrl_if;
   import dcm_pkg::*;

   logic                req;
   phase_t              target;
   logic                busy;
   phase_t              cur_phase;
   logic                ready;
   logic                err_ovf;
   logic [RELOCK_W-1:0] relock_cnt;

   modport master (
      output req, target,
      input  busy, cur_phase, ready, err_ovf, relock_cnt
   );

   modport slave (
      input  req, target,
      output busy, cur_phase, ready, err_ovf, relock_cnt
   );

endinterface

// File: rtl/dcm_timeout_cnt.sv
// dcm_timeout_cnt: down-counter watchdog shared by the lock and ps_done waits.
//   clk, reset_n  clock and synchronous active-low reset
//   load          reload the counter to LIMIT-1 (wins over en)
//   en            count down one per cycle while waiting
//   expire_c      high in the LIMIT-th consecutive enabled cycle
module dcm_timeout_cnt #(
   parameter int unsigned LIMIT = 65535
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] cnt;

   // Reload value LIMIT-1 makes the wait last exactly LIMIT cycles.
   always_ff @(posedge clk) begin
      if (!reset_n || load) begin
         cnt <= CNT_W'(LIMIT - 1);
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expire_c = en && (cnt == '0);

endmodule

// File: rtl/dcm_ps_ctrl.sv
// dcm_ps_ctrl: drives the DCM dynamic phase-shift port (PSEN/PSINCDEC/PSDONE)
// to walk the phase one step at a time toward a requested target, and owns the
// DCM reset / lock-recovery sequence.
//   clk, reset_n  sole clock (also DCM PSCLK), synchronous active-low reset
//   ctl           user request/status bundle (slave side)
//   dcm_rst       DCM RST
//   ps_en         DCM PSEN (single-cycle pulses)
//   ps_incdec     DCM PSINCDEC, 1 = increment
//   ps_done       DCM PSDONE
//   dcm_locked    DCM LOCKED
//   dcm_status    DCM STATUS; bit0 phase overflow, bit1 CLKIN stopped
module dcm_ps_ctrl
   import dcm_pkg::*;
#(
   parameter int          INIT_PHASE   = 0,
   parameter int          PS_LIMIT     = 255,
   parameter int unsigned RST_CYCLES   = 3,
   parameter int unsigned LOCK_TIMEOUT = 65535
) (
   input  logic                clk,
   input  logic                reset_n,
   dcm_ps_ctrl_if.slave        ctl,
   output logic                dcm_rst,
   output logic                ps_en,
   output logic                ps_incdec,
   input  logic                ps_done,
   input  logic                dcm_locked,
   input  logic [STATUS_W-1:0] dcm_status
);

   localparam int unsigned RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam phase_t      INIT_P = PHASE_W'(INIT_PHASE);
   localparam phase_t      ONE_P  = PHASE_W'(1);

   ps_state_t           state;
   logic [RCNT_W-1:0]   rst_cnt;
   phase_t              cur_phase;
   phase_t              goal;
   logic                err_ovf;
   logic [RELOCK_W-1:0] relock_cnt;

   logic   unlock_c;
   logic   lost_c;
   logic   tmo_en_c;
   logic   tmo_c;
   phase_t goal_c;
   phase_t next_phase_c;
   logic   unused_status_c;

   // Lock loss or stopped input clock while the DCM is supposed to be running.
   assign unlock_c = !dcm_locked || dcm_status[1];
   assign lost_c   = unlock_c &&
                     ((state == IDLE) || (state == STEP) || (state == WAIT_DONE));

   assign goal_c       = clamp_phase(ctl.target, PS_LIMIT);
   assign next_phase_c = ps_incdec ? (cur_phase + ONE_P) : (cur_phase - ONE_P);

   // Watchdog runs only in the two wait states and is preloaded everywhere else.
   assign tmo_en_c = (state == WAIT_LOCK) || (state == WAIT_DONE);

   dcm_timeout_cnt #(
      .LIMIT (LOCK_TIMEOUT)
   ) u_tmo (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (!tmo_en_c),
      .en       (tmo_en_c),
      .expire_c (tmo_c)
   );

   // Controller state machine.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= RST_DCM;
         rst_cnt   <= '0;
         cur_phase <= INIT_P;
         goal      <= INIT_P;
         ps_incdec <= 1'b0;
         err_ovf   <= 1'b0;
      end else if (lost_c) begin
         // Recovery outranks any same-cycle ps_done or req.
         state     <= RST_DCM;
         cur_phase <= INIT_P;
         goal      <= INIT_P;
      end else begin
         case (state)
            RST_DCM: begin
               cur_phase <= INIT_P;
               goal      <= INIT_P;
               if (rst_cnt == RCNT_W'(RST_CYCLES - 1)) begin
                  rst_cnt <= '0;
                  state   <= WAIT_LOCK;
               end else begin
                  rst_cnt <= rst_cnt + RCNT_W'(1);
               end
            end

            WAIT_LOCK: begin
               if (dcm_locked) begin
                  state <= IDLE;
               end else if (tmo_c) begin
                  state <= RST_DCM;
               end
            end

            IDLE: begin
               if (ctl.req) begin
                  goal <= goal_c;
                  if (goal_c != cur_phase) begin
                     state     <= STEP;
                     ps_incdec <= (goal_c > cur_phase);
                  end
               end
            end

            STEP: begin
               state <= WAIT_DONE;
            end

            WAIT_DONE: begin
               if (ps_done) begin
                  if (dcm_status[0]) begin
                     // Overflow: DCM did not move, drop the goal.
                     err_ovf <= 1'b1;
                     goal    <= cur_phase;
                     state   <= IDLE;
                  end else begin
                     cur_phase <= next_phase_c;
                     state     <= (next_phase_c == goal) ? IDLE : STEP;
                  end
               end else if (tmo_c) begin
                  state <= RST_DCM;
               end
            end

            default: begin
               state <= RST_DCM;
            end
         endcase
      end
   end

   // Saturating count of lock-loss recoveries.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         relock_cnt <= '0;
      end else if (lost_c && (relock_cnt != '1)) begin
         relock_cnt <= relock_cnt + RELOCK_W'(1);
      end
   end

   // DCM strobes are pure decodes of the state register: no input-to-output path.
   assign dcm_rst = (state == RST_DCM);
   assign ps_en   = (state == STEP);

   assign ctl.busy       = (state != IDLE);
   assign ctl.ready      = (state == IDLE) && dcm_locked;
   assign ctl.cur_phase  = cur_phase;
   assign ctl.err_ovf    = err_ovf;
   assign ctl.relock_cnt = relock_cnt;

   assign unused_status_c = ^dcm_status[STATUS_W-1:2];

endmodule
